// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path: character width, feeder FSM states
// and the idle value driven on the UART_TX data input.
package uart_pkg;

  localparam int DATA_W_DEF = 8;

  localparam logic [DATA_W_DEF-1:0] TX_D_RST = '0;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    START,
    WAIT
  } tx_feed_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Circular byte buffer with a separately tracked occupancy count; 1-cycle write latency.
// Back-pressure via registered full (no write-through when full); sticky overflow on rejected writes.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              flush,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

  // flush takes priority over both ports so a flushed cycle never moves data
  assign push = wr_en && !full && !flush;
  assign pop  = rd_en && !empty && !flush;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en && full && !flush) begin
        overflow <= 1'b1;
      end
      if (flush) begin
        rd_ptr <= wr_ptr;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers host bytes and hands them to UART_TX one at a time; write-to-tx_start is 3 cycles when idle.
// Host back-pressure is the full flag; the next byte is issued only after tx_done.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_d,
  input  logic              tx_done,
  output logic              busy
);

  tx_feed_state_t    state;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              pop;

  assign pop = (state == LOAD);

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .flush    (flush),
    .rd_data  (fifo_rd_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_d     <= DATA_W'(TX_D_RST);
      busy     <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        // a flush in this cycle empties the queue, so do not commit to a byte
        IDLE: begin
          if (!empty && !flush) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          tx_d     <= fifo_rd_data;
          tx_start <= 1'b1;
          state    <= START;
        end
        START: begin
          state <= WAIT;
        end
        WAIT: begin
          if (tx_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based reference.
module tb_uart_tx_feeder;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       tx_start;
  logic [7:0] tx_d;
  logic       tx_done;
  logic       busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_feeder #(.DATA_W(8), .DEPTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_start (tx_start),
    .tx_d     (tx_d),
    .tx_done  (tx_done),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a byte queue plus "cycles since the feeder picked up work".
  // age 0 = byte being fetched, 1 = tx_start cycle, 2 = waiting on tx_done.
  logic [7:0] q[$];
  bit         m_valid = 1'b0;
  bit         m_busy;
  bit         m_start;
  bit         m_ovf;
  int         m_age;
  logic [7:0] m_txd;

  always @(posedge clk) begin
    int sz;
    if (reset) begin
      q.delete();
      m_busy  = 1'b0;
      m_start = 1'b0;
      m_ovf   = 1'b0;
      m_age   = 0;
      m_txd   = 8'h00;
      m_valid = 1'b1;
    end else if (m_valid) begin
      sz      = q.size();
      m_start = 1'b0;
      if (!m_busy) begin
        if (sz > 0 && !flush) begin
          m_busy = 1'b1;
          m_age  = 0;
        end
      end else if (m_age == 0) begin
        m_txd   = q.pop_front();
        m_start = 1'b1;
        m_age   = 1;
      end else begin
        if (m_age >= 2 && tx_done) m_busy = 1'b0;
        m_age = 2;
      end
      if (flush) begin
        q.delete();
      end else if (wr_en) begin
        if (sz < 16) q.push_back(wr_data);
        else         m_ovf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("m_count",    32'(count),    32'(q.size()));
      check("m_empty",    32'(empty),    32'(q.size() == 0));
      check("m_full",     32'(full),     32'(q.size() == 16));
      check("m_busy",     32'(busy),     32'(m_busy));
      check("m_tx_start", 32'(tx_start), 32'(m_start));
      check("m_tx_d",     32'(tx_d),     32'(m_txd));
      check("m_overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_empty"},    32'(empty),    1);
    check({tag, "_full"},     32'(full),     0);
    check({tag, "_count"},    32'(count),    0);
    check({tag, "_overflow"}, 32'(overflow), 0);
    check({tag, "_tx_start"}, 32'(tx_start), 0);
    check({tag, "_tx_d"},     32'(tx_d),     0);
    check({tag, "_busy"},     32'(busy),     0);
  endtask

  initial begin
    int n;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    flush   = 1'b0;
    tx_done = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;
    repeat (7) @(negedge clk);

    // single byte: empty clears at N+1, LOAD at N+2, tx_start at N+3
    wr_en = 1'b1; wr_data = 8'hA5;
    @(negedge clk);
    wr_en = 1'b0;
    check("a5_empty", 32'(empty), 0);
    check("a5_count", 32'(count), 1);
    check("a5_start_early", 32'(tx_start), 0);
    @(negedge clk);
    check("a5_busy_load", 32'(busy), 1);
    check("a5_start_load", 32'(tx_start), 0);
    @(negedge clk);
    check("a5_start", 32'(tx_start), 1);
    check("a5_tx_d", 32'(tx_d), 32'hA5);
    check("a5_empty_after_load", 32'(empty), 1);
    repeat (4) begin
      @(negedge clk);
      check("a5_hold", 32'(tx_d), 32'hA5);
      check("a5_single_pulse", 32'(tx_start), 0);
      check("a5_busy_wait", 32'(busy), 1);
    end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check("a5_busy_drop", 32'(busy), 0);
    check("a5_tx_d_kept", 32'(tx_d), 32'hA5);
    repeat (3) begin
      @(negedge clk);
      check("a5_no_restart", 32'(tx_start), 0);
    end

    // burst with UART stalled: first byte leaves, so 16 writes peak at 15
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = i[7:0];
      @(negedge clk);
      check("burst_not_full", 32'(full), 0);
      if (tx_start) begin
        check("burst_first", 32'(tx_d), 0);
        n++;
      end
    end
    check("burst_peak", 32'(count), 15);
    wr_data = 8'h10;
    @(negedge clk);
    check("burst_full", 32'(full), 1);
    check("burst_count16", 32'(count), 16);
    check("burst_no_ovf_yet", 32'(overflow), 0);
    wr_data = 8'h11;
    @(negedge clk);
    wr_en = 1'b0;
    check("burst_ovf", 32'(overflow), 1);
    check("burst_count_kept", 32'(count), 16);
    for (int c = 0; c < 600 && n < 17; c++) begin
      tx_done = (c % 5 == 4);
      @(negedge clk);
      if (tx_start) begin
        check("burst_order", 32'(tx_d), 32'(n));
        n++;
      end
    end
    tx_done = 1'b0;
    check("burst_bytes_out", 32'(n), 17);
    check("burst_ovf_sticky", 32'(overflow), 1);
    check("burst_drained", 32'(empty), 1);

    // flush during WAIT with four bytes queued
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'h30 + i[7:0];
      @(negedge clk);
    end
    wr_en = 1'b0;
    check("fl_queued", 32'(count), 4);
    check("fl_busy", 32'(busy), 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fl_count", 32'(count), 0);
    check("fl_inflight_busy", 32'(busy), 1);
    check("fl_inflight_d", 32'(tx_d), 32'h30);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check("fl_done", 32'(busy), 0);
    repeat (8) begin
      @(negedge clk);
      check("fl_no_start", 32'(tx_start), 0);
      check("fl_idle", 32'(busy), 0);
    end

    // reset during WAIT
    for (int i = 0; i < 2; i++) begin
      wr_en = 1'b1; wr_data = 8'h40 + i[7:0];
      @(negedge clk);
    end
    wr_en = 1'b0;
    repeat (2) @(negedge clk);
    check("rw_busy", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_vals("rw");
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("rw_no_start", 32'(tx_start), 0);
      check("rw_idle", 32'(busy), 0);
    end

    // randomized traffic against the reference
    for (int c = 0; c < 3000; c++) begin
      wr_en   = ($urandom_range(0, 2) != 0);
      wr_data = 8'($urandom);
      flush   = ($urandom_range(0, 39) == 0);
      tx_done = ($urandom_range(0, 5) == 0);
      reset   = ($urandom_range(0, 599) == 0);
      @(negedge clk);
    end
    wr_en = 1'b0; flush = 1'b0; tx_done = 1'b0; reset = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
